// File: rtl/dco_sweep_pkg.sv
// dco_sweep_pkg: FSM state encoding and DCO pipeline latency
// shared by the DCO frequency sweep controller.
package dco_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DWELL  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // DCO: 1 increment reg + 1 phase reg + 4 table stages
    localparam int DEFAULT_SETTLE_CYCLES = 6;

endpackage

// File: rtl/dco_sweep_controller_down_counter.sv
// down_counter: loadable down counter with clock enable and
// a zero flag; stops at zero.
module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (ce) begin
            if (load) begin
                count <= value;
            end else if (en && count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dco_sweep_controller.sv
// dco_sweep_controller: steps the DCO phase increment through a
// programmed sweep, with settle and sample-window timing per point.
module dco_sweep_controller
    import dco_sweep_pkg::*;
#(
    parameter int PHASE_INCREMENT_BITS = 28,
    parameter int POINT_BITS           = 12,
    parameter int DWELL_BITS           = 16,
    parameter int SETTLE_CYCLES        = DEFAULT_SETTLE_CYCLES
) (
    input  logic                            CLK,
    input  logic                            CE,
    input  logic                            RESET,
    input  logic                            START,
    input  logic                            ABORT,
    input  logic [PHASE_INCREMENT_BITS-1:0] START_INC,
    input  logic [PHASE_INCREMENT_BITS-1:0] STEP_INC,
    input  logic [POINT_BITS-1:0]           NUM_POINTS,
    input  logic [DWELL_BITS-1:0]           DWELL_CYCLES,
    output logic [PHASE_INCREMENT_BITS-1:0] PHASE_INCREMENT_OUT,
    output logic                            PHASE_INCREMENT_OUT_WE,
    output logic                            SAMPLE_VALID,
    output logic [POINT_BITS-1:0]           POINT_INDEX,
    output logic                            BUSY,
    output logic                            DONE
);

    localparam int SETTLE_BITS =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_BITS-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? SETTLE_BITS'(SETTLE_CYCLES - 1) : '0;

    state_t                          state;
    logic [PHASE_INCREMENT_BITS-1:0] step_q;
    logic [POINT_BITS-1:0]           num_q;
    logic [DWELL_BITS-1:0]           dwell_q;
    logic [DWELL_BITS-1:0]           dwell_value;
    logic                            settle_load;
    logic                            settle_en;
    logic                            settle_zero;
    logic                            dwell_load;
    logic                            dwell_en;
    logic                            dwell_zero;
    logic                            more_points;

    // A zero dwell still gives one sample cycle
    assign dwell_value = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
    assign settle_load = (state == ST_LOAD);
    assign settle_en   = (state == ST_SETTLE);
    assign dwell_load  = (state == ST_LOAD && SETTLE_CYCLES == 0)
                      || (state == ST_SETTLE && settle_zero);
    assign dwell_en    = (state == ST_DWELL);
    assign more_points = (POINT_INDEX < num_q - 1'b1);

    down_counter #(.WIDTH(SETTLE_BITS)) u_settle (
        .clk   (CLK),
        .rst   (RESET),
        .ce    (CE),
        .load  (settle_load),
        .en    (settle_en),
        .value (SETTLE_LOAD),
        .zero  (settle_zero)
    );

    down_counter #(.WIDTH(DWELL_BITS)) u_dwell (
        .clk   (CLK),
        .rst   (RESET),
        .ce    (CE),
        .load  (dwell_load),
        .en    (dwell_en),
        .value (dwell_value),
        .zero  (dwell_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state                  <= ST_IDLE;
            step_q                 <= '0;
            num_q                  <= '0;
            dwell_q                <= '0;
            PHASE_INCREMENT_OUT    <= '0;
            PHASE_INCREMENT_OUT_WE <= 1'b0;
            SAMPLE_VALID           <= 1'b0;
            POINT_INDEX            <= '0;
            BUSY                   <= 1'b0;
            DONE                   <= 1'b0;
        end else if (CE) begin
            PHASE_INCREMENT_OUT_WE <= 1'b0;
            DONE                   <= 1'b0;
            if (ABORT && state != ST_IDLE) begin
                state        <= ST_IDLE;
                SAMPLE_VALID <= 1'b0;
                BUSY         <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (START && !ABORT) begin
                            BUSY <= 1'b1;
                            if (NUM_POINTS == '0) begin
                                state <= ST_DONE;
                                DONE  <= 1'b1;
                            end else begin
                                step_q                 <= STEP_INC;
                                num_q                  <= NUM_POINTS;
                                dwell_q                <= DWELL_CYCLES;
                                PHASE_INCREMENT_OUT    <= START_INC;
                                PHASE_INCREMENT_OUT_WE <= 1'b1;
                                POINT_INDEX            <= '0;
                                state                  <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (SETTLE_CYCLES == 0) begin
                            state        <= ST_DWELL;
                            SAMPLE_VALID <= 1'b1;
                        end else begin
                            state <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_zero) begin
                            state        <= ST_DWELL;
                            SAMPLE_VALID <= 1'b1;
                        end
                    end
                    ST_DWELL: begin
                        if (dwell_zero) begin
                            SAMPLE_VALID <= 1'b0;
                            if (more_points) begin
                                PHASE_INCREMENT_OUT    <= PHASE_INCREMENT_OUT + step_q;
                                PHASE_INCREMENT_OUT_WE <= 1'b1;
                                POINT_INDEX            <= POINT_INDEX + 1'b1;
                                state                  <= ST_LOAD;
                            end else begin
                                state <= ST_DONE;
                                DONE  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
